// File: rtl/operand_issue_stage_pkg.sv
// Shared types and constants for the operand issue stage and its load scoreboard.
package operand_issue_stage_pkg;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int OPW   = 8;
  localparam int NREGS = 64;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] data_t;

  // Contents of the one-entry pipeline register presented to execute.
  typedef struct packed {
    reg_addr_t      dst;
    logic           dst_we;
    logic           is_load;
    logic [OPW-1:0] op;
    data_t          a;
    data_t          b;
  } issue_pkt_t;

endpackage

// File: rtl/operand_issue_stage_load_scoreboard.sv
// Load scoreboard: one pending bit per architectural register.
// A bit is set when a load leaves for execute and cleared when its
// write-back arrives. If both happen to one register in the same cycle the
// set wins, because the newly issued load is the one still outstanding.
module load_scoreboard
  import operand_issue_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t lk_addr1,
  input  reg_addr_t lk_addr2,
  output logic      lk_hit1,
  output logic      lk_hit2
);

  logic [NREGS-1:0] sb_r;
  logic [NREGS-1:0] sb_nxt_s;

  // Next scoreboard state: apply clear first so a same-address set overrides it.
  always_comb begin
    sb_nxt_s = sb_r;
    if (clr_en) begin
      sb_nxt_s[clr_addr] = 1'b0;
    end else begin
      sb_nxt_s = sb_nxt_s;
    end
    if (set_en) begin
      sb_nxt_s[set_addr] = 1'b1;
    end else begin
      sb_nxt_s = sb_nxt_s;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_r <= {NREGS{1'b0}};
    end else begin
      sb_r <= sb_nxt_s;
    end
  end

  // Two lookup ports against the registered state.
  always_comb begin
    lk_hit1 = sb_r[lk_addr1];
    lk_hit2 = sb_r[lk_addr2];
  end

endmodule

// File: rtl/operand_issue_stage.sv
// Operand issue stage: reads the register file, bypasses the write-back
// value, stalls on registers with an outstanding load and holds the operands
// in a one-entry register handed to execute over valid/ready.
module operand_issue_stage
  import operand_issue_stage_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 6,
  parameter int OPW  = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_ra1,
  input  logic [AW-1:0]   in_ra2,
  input  logic [AW-1:0]   in_dst,
  input  logic            in_dst_we,
  input  logic            in_is_load,
  input  logic [OPW-1:0]  in_op,
  output logic [AW-1:0]   rf_ra1,
  output logic [AW-1:0]   rf_ra2,
  input  logic [DW-1:0]   rf_rd1,
  input  logic [DW-1:0]   rf_rd2,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_wa,
  input  logic [DW-1:0]   wb_wd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_a,
  output logic [DW-1:0]   out_b,
  output logic [AW-1:0]   out_dst,
  output logic            out_dst_we,
  output logic            out_is_load,
  output logic [OPW-1:0]  out_op,
  output logic [CNTW-1:0] stall_cnt
);

  issue_pkt_t      pkt_r;
  issue_pkt_t      pkt_nxt_s;
  logic            valid_r;
  logic [CNTW-1:0] stall_cnt_r;
  logic            byp1_s;
  logic            byp2_s;
  logic            hit1_s;
  logic            hit2_s;
  logic            hz_s;
  logic            fire_in_s;
  logic            fire_out_s;
  logic            sb_set_s;

  // Pending-load tracking; only loads that actually hand off to execute count.
  load_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set_s),
    .set_addr (pkt_r.dst),
    .clr_en   (wb_we),
    .clr_addr (wb_wa),
    .lk_addr1 (in_ra1),
    .lk_addr2 (in_ra2),
    .lk_hit1  (hit1_s),
    .lk_hit2  (hit2_s)
  );

  // Operand select, hazard detection and handshake decisions.
  always_comb begin
    rf_ra1     = in_ra1;
    rf_ra2     = in_ra2;
    byp1_s     = wb_we && (wb_wa == in_ra1);
    byp2_s     = wb_we && (wb_wa == in_ra2);
    // A write-back landing this cycle satisfies the dependency it resolves.
    hz_s       = in_valid && ((hit1_s && !byp1_s) || (hit2_s && !byp2_s));
    fire_out_s = valid_r && out_ready && !flush;
    // Flush frees the slot, so acceptance ignores the entry being killed.
    in_ready   = (!valid_r || out_ready || flush) && !hz_s;
    fire_in_s  = in_valid && in_ready;
    sb_set_s   = fire_out_s && pkt_r.is_load && pkt_r.dst_we;

    pkt_nxt_s         = '0;
    pkt_nxt_s.dst     = in_dst;
    pkt_nxt_s.dst_we  = in_dst_we;
    pkt_nxt_s.is_load = in_is_load;
    pkt_nxt_s.op      = in_op;
    pkt_nxt_s.a       = byp1_s ? wb_wd : rf_rd1;
    pkt_nxt_s.b       = byp2_s ? wb_wd : rf_rd2;
  end

  // One-entry pipeline register toward execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      pkt_r   <= '0;
    end else if (fire_in_s) begin
      valid_r <= 1'b1;
      pkt_r   <= pkt_nxt_s;
    end else if (fire_out_s || flush) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Saturating count of cycles lost to load-use hazards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNTW{1'b0}};
    end else if (hz_s && (stall_cnt_r != {CNTW{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Registered outputs driven straight from the pipeline state.
  always_comb begin
    out_valid   = valid_r;
    out_a       = pkt_r.a;
    out_b       = pkt_r.b;
    out_dst     = pkt_r.dst;
    out_dst_we  = pkt_r.dst_we;
    out_is_load = pkt_r.is_load;
    out_op      = pkt_r.op;
    stall_cnt   = stall_cnt_r;
  end

endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the 64-entry register file.
- Drives the regfile read addresses and captures the read data into a one-entry pipeline register.
- Applies write-back bypass and stalls on source registers with outstanding loads, tracked by a load scoreboard.
- Presents the operands to execute over a valid/ready handshake, and counts stall cycles for performance monitoring.

Parameters:
- DW, 32, operand/data width in bits
- AW, 6, register address width (64 registers)
- OPW, 8, opaque opcode width passed through to execute
- CNTW, 16, width of the stall performance counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_ra1  in  AW  source register 1 address
- in_ra2  in  AW  source register 2 address
- in_dst  in  AW  destination register address
- in_dst_we  in  1  instruction writes in_dst
- in_is_load  in  1  instruction is a load; result arrives later via write-back
- in_op  in  OPW  opcode, passed through
- rf_ra1  out  AW  regfile read address 1, equal to in_ra1 (combinational)
- rf_ra2  out  AW  regfile read address 2, equal to in_ra2 (combinational)
- rf_rd1  in  DW  regfile read data 1 (combinational, pre-write value)
- rf_rd2  in  DW  regfile read data 2
- wb_we  in  1  write-back writes the regfile this cycle
- wb_wa  in  AW  write-back address
- wb_wd  in  DW  write-back data
- flush  in  1  kill the held instruction
- out_valid  out  1  operands valid for execute
- out_ready  in  1  execute accepts
- out_a  out  DW  operand 1
- out_b  out  DW  operand 2
- out_dst  out  AW  destination
- out_dst_we  out  1  destination write enable
- out_is_load  out  1  load flag
- out_op  out  OPW  opcode
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, all other out_* fields=0, scoreboard=all zeros, stall_cnt=0.
- Operand select: op1 = (wb_we && wb_wa==in_ra1) ? wb_wd : rf_rd1; op2 is selected the same way from in_ra2 and rf_rd2.
- Hazard: hz = in_valid && ((sb[in_ra1] && !(wb_we && wb_wa==in_ra1)) || (sb[in_ra2] && !(wb_we && wb_wa==in_ra2))).
- Handshake:
  - fire_out = out_valid && out_ready && !flush.
  - in_ready = (!out_valid || out_ready || flush) && !hz.
  - fire_in = in_valid && in_ready.
- Pipeline register:
  - On fire_in, load op1/op2 and the in_* fields into out_*, and set out_valid=1. Latency is 1 cycle.
  - Otherwise, if fire_out or flush, set out_valid=0.
  - Otherwise, hold all out_* fields stable while out_valid && !out_ready.
- Flush:
  - Drops the held entry. Execute ignores out_valid during a flush cycle.
  - A new instruction presented in the same cycle as flush is accepted (in_ready does not depend on the flushed entry).
- Scoreboard (64 bits, sb):
  - Set: sb[out_dst] is set on fire_out when out_is_load && out_dst_we.
  - Clear: sb[wb_wa] is cleared when wb_we.
  - Same address set and cleared in one cycle: set wins (the newer load is outstanding).
  - A flushed load never sets its bit.
- stall_cnt: increments by 1 each cycle hz=1 and saturates at 2^CNTW-1, with no wrap.
- in_ra1 == in_ra2 is legal; both operands receive the same value.
- Register 0 is not special.

Decomposition:
- Shared package:
  - Constants for AW, DW, OPW and NREGS=64.
  - typedef reg_addr_t (AW bits), data_t (DW bits).
  - Packed struct issue_pkt_t {dst, dst_we, is_load, op, a, b} used for the pipeline register.
- One natural sub-module: load_scoreboard.
  - Holds the 64-bit set/clear vector with set-wins priority.
  - Two combinational lookup ports.

Test Plan:
- Reset, then issue ra1=3, ra2=4 with rf_rd1=0x11, rf_rd2=0x22 and out_ready=1 -> next cycle out_valid=1, out_a=0x11, out_b=0x22.
- Bypass: in_ra1=5 with wb_we=1, wb_wa=5, wb_wd=0xDEAD and rf_rd1=0x0 in the same cycle -> captured out_a=0xDEAD.
- Load-use: issue load with dst=7, it fires out; next instruction has ra2=7 -> in_ready=0 and stall_cnt increments each cycle. Then wb_we=1, wb_wa=7, wb_wd=0x55 -> accepted that cycle with out_b=0x55, and sb[7]=0 afterwards.
- Backpressure: out_ready=0 for 3 cycles with an entry held -> out_* fields stable, in_ready=0; out_ready=1 -> handoff with no loss or duplication.
- Flush: held load with dst=9 and flush=1 while out_ready=1 -> out_valid=0 next cycle, sb[9] stays 0, and a later instruction reading r9 does not stall.
- Async reset mid-stall (rst_n low between clock edges) -> out_valid=0 and stall_cnt=0 immediately, scoreboard cleared.
